// File: rtl/pid_pkg.sv
// pid_pkg: shared state type, fixed-point formats and saturation helpers for pid_sched
package pid_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MUL_P, MUL_I, MUL_D, SAT, OUT} state_t;
  localparam int FRAC = 8;
  localparam int ACC_W = 52;
  function automatic logic signed [31:0] sat32(input logic signed [32:0] x);
    return (x[32] ^ x[31]) ? {x[32], {31{~x[32]}}} : x[31:0];
  endfunction
  function automatic logic signed [63:0] clamp_sym(input logic signed [63:0] x, input logic signed [63:0] m);
    return x > m ? m : x < -m ? -m : x;
  endfunction
endpackage

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: free-running sample-period counter with enable-gated tick
module pid_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) count <= '0;
    else count <= (count == CW'(TICK_DIV - 1)) ? '0 : count + CW'(1);
  assign tick = en && (count == CW'(TICK_DIV - 1));
endmodule

// File: rtl/pid_sched.sv
// pid_sched: time-multiplexed PID loops sharing one signed multiplier
module pid_sched
  import pid_pkg::*;
#(
  parameter int NCH = 2,
  parameter int TICK_DIV = 1000,
  parameter int ITG_MAX = 100000000,
  parameter int OUT_MAX = 2147483647
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  en,
  input  logic                                  clr,
  input  logic [32*NCH-1:0]                     sig_in,
  input  logic [32*NCH-1:0]                     target,
  input  logic signed [15:0]                    kp,
  input  logic signed [15:0]                    ki,
  input  logic signed [15:0]                    kd,
  output logic signed [31:0]                    u,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] u_ch,
  output logic                                  u_valid,
  output logic                                  busy,
  output logic                                  overrun
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  state_t state;
  logic tick;
  logic [CHW-1:0] ch;
  logic signed [31:0] e1 [NCH];
  logic signed [33:0] sum [NCH];
  logic signed [31:0] e;
  logic signed [32:0] d;
  logic signed [33:0] sum_new;
  logic signed [ACC_W-1:0] acc;
  logic signed [31:0] sig_c, tgt_c, e_c;
  logic signed [32:0] d_c;
  logic signed [33:0] sum_c, opa;
  logic signed [15:0] opb;
  logic signed [49:0] prod;
  pid_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rstn(rstn), .en(en), .tick(tick));
  assign sig_c = sig_in[32*int'(ch) +: 32];
  assign tgt_c = target[32*int'(ch) +: 32];
  assign e_c = sat32(33'(tgt_c) - 33'(sig_c));
  assign d_c = 33'(e_c) - 33'(e1[ch]);
  assign sum_c = 34'(clamp_sym(64'(sum[ch]) + 64'(e_c), 64'(ITG_MAX)));
  assign opa = (state == MUL_P) ? 34'(e) : (state == MUL_I) ? sum_new : 34'(d);
  assign opb = (state == MUL_P) ? kp : (state == MUL_I) ? ki : kd;
  assign prod = 50'(opa) * 50'(opb);
  assign busy = (state != IDLE);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      ch <= '0;
      e <= '0;
      d <= '0;
      sum_new <= '0;
      acc <= '0;
      u <= '0;
      u_ch <= '0;
      u_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        e1[i] <= '0;
        sum[i] <= '0;
      end
    end else if (clr) begin
      state <= IDLE;
      ch <= '0;
      u_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        e1[i] <= '0;
        sum[i] <= '0;
      end
    end else begin
      u_valid <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          ch <= '0;
          state <= LOAD;
        end
        LOAD: begin
          e <= e_c;
          d <= d_c;
          sum_new <= sum_c;
          acc <= '0;
          state <= MUL_P;
        end
        MUL_P: begin
          acc <= acc + 52'(prod);
          state <= MUL_I;
        end
        MUL_I: begin
          acc <= acc + 52'(prod);
          state <= MUL_D;
        end
        MUL_D: begin
          acc <= acc + 52'(prod);
          state <= SAT;
        end
        SAT: begin
          u <= 32'(clamp_sym(64'(acc >>> FRAC), 64'(OUT_MAX)));
          u_ch <= ch;
          u_valid <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          e1[ch] <= e;
          sum[ch] <= sum_new;
          ch <= ch + CHW'(1);
          state <= (ch == CHW'(NCH - 1)) ? IDLE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pid_sched.sv
// tb_pid_sched: randomized and directed checking of pid_sched against a frame-level PID model
module tb_pid_sched;
  localparam int NCH = 2;
  localparam int TD = 16;
  localparam longint ITG = 100000000;
  localparam longint OMAX = 2147483647;
  localparam longint P31 = 64'sd2147483648;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b1, clr = 1'b0;
  logic [32*NCH-1:0] sig_in = '0, target = '0;
  logic signed [15:0] kp = '0, ki = '0, kd = '0;
  logic signed [31:0] u1, u2;
  logic [0:0] uch1, uch2;
  logic uv1, uv2, busy1, busy2, ovr1, ovr2;
  int vectors = 0, miscompares = 0;
  int m_phase = 0, m_count = 0, uch_exp = 0;
  longint m_e1 [NCH], m_sum [NCH], m_res [NCH], m_pe [NCH], m_ps [NCH];
  longint u_exp = 0;
  bit ovr_exp = 1'b0;
  pid_sched #(.NCH(NCH), .TICK_DIV(TD)) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .sig_in(sig_in), .target(target),
    .kp(kp), .ki(ki), .kd(kd), .u(u1), .u_ch(uch1), .u_valid(uv1), .busy(busy1), .overrun(ovr1)
  );
  pid_sched #(.NCH(NCH), .TICK_DIV(8)) dut_fast (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .sig_in(sig_in), .target(target),
    .kp(kp), .ki(ki), .kd(kd), .u(u2), .u_ch(uch2), .u_valid(uv2), .busy(busy2), .overrun(ovr2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic miss(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event, expected one within bound at %0t", name, $time);
  endtask
  function automatic longint clampl(input longint x, input longint m);
    return x > m ? m : x < -m ? -m : x;
  endfunction
  task automatic model_load(input int c);
    longint sg, tg, ev, dv, s, a;
    sg = longint'($signed(sig_in[32*c +: 32]));
    tg = longint'($signed(target[32*c +: 32]));
    ev = tg - sg;
    ev = ev > P31 - 1 ? P31 - 1 : ev < -P31 ? -P31 : ev;
    dv = ev - m_e1[c];
    s = clampl(m_sum[c] + ev, ITG);
    a = ev * longint'(kp) + s * longint'(ki) + dv * longint'(kd);
    m_res[c] = clampl(a >>> 8, OMAX);
    m_pe[c] = ev;
    m_ps[c] = s;
  endtask
  always @(negedge clk) begin : model
    int p;
    bit ev, tk;
    if (!rstn) begin
      m_phase = 0;
      m_count = 0;
      ovr_exp = 1'b0;
      u_exp = 0;
      uch_exp = 0;
      foreach (m_e1[i]) begin
        m_e1[i] = 0;
        m_sum[i] = 0;
      end
    end
    p = m_phase;
    ev = p >= 1 && p % 6 == 0;
    if (ev) begin
      u_exp = m_res[p/6-1];
      uch_exp = p / 6 - 1;
    end
    chk("u_valid", uv1, ev);
    chk("busy", busy1, p >= 1);
    chk("overrun", ovr1, ovr_exp);
    chk("u", u1, u_exp);
    chk("u_ch", uch1, uch_exp);
    if (rstn) begin
      if (clr) begin
        m_phase = 0;
        ovr_exp = 1'b0;
        foreach (m_e1[i]) begin
          m_e1[i] = 0;
          m_sum[i] = 0;
        end
      end else begin
        if (p >= 1 && p % 6 == 1) model_load((p - 1) / 6);
        if (ev) begin
          m_e1[p/6-1] = m_pe[p/6-1];
          m_sum[p/6-1] = m_ps[p/6-1];
        end
        tk = (m_count == TD - 1) && en;
        if (tk && p >= 1) ovr_exp = 1'b1;
        m_phase = p >= 1 ? (p == 6 * NCH ? 0 : p + 1) : (tk ? 1 : 0);
      end
      m_count = (m_count + 1) % TD;
    end
  end
  task automatic set_ch(input int c, input logic [31:0] t, input logic [31:0] s);
    target[32*c +: 32] = t;
    sig_in[32*c +: 32] = s;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_clr();
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
  endtask
  task automatic wait_ch0(input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = uv1 && uch1 == 1'b0;
    end
    if (!hit) miss(name);
  endtask
  task automatic wait_idle();
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = !busy1;
    end
    if (!hit) miss("idle");
    next_cycle();
  endtask
  function automatic logic [31:0] rnd32();
    int unsigned k = $urandom % 3;
    return k == 0 ? 32'($urandom_range(4000) - 2000) : k == 1 ? 32'($urandom_range(400000000) - 200000000) : $urandom;
  endfunction
  function automatic logic [15:0] rgain();
    return ($urandom % 2 == 0) ? 16'($urandom_range(1024) - 512) : 16'($urandom);
  endfunction
  initial begin
    bit hit;
    kp = 16'sh0100;
    set_ch(0, 32'd1000, 32'd400);
    set_ch(1, -32'sd50, 32'd50);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u", u1, 0);
    chk("rst_valid", uv1, 0);
    chk("rst_busy", busy1, 0);
    next_cycle();
    rstn = 1'b1;
    repeat (21) @(negedge clk);
    chk("p_pre_valid", uv1, 0);
    chk("p_pre_busy", busy1, 1);
    @(negedge clk);
    chk("p_ch0_valid", uv1, 1);
    chk("p_ch0_u", u1, 600);
    chk("p_ch0_ch", uch1, 0);
    repeat (6) @(negedge clk);
    chk("p_ch1_valid", uv1, 1);
    chk("p_ch1_u", u1, -100);
    chk("p_ch1_ch", uch1, 1);
    @(negedge clk);
    chk("p_busy_drop", busy1, 0);
    wait_idle();
    kp = '0;
    ki = 16'sh0100;
    set_ch(0, 32'd60000000, 32'd0);
    set_ch(1, 32'd0, 32'd0);
    pulse_clr();
    wait_ch0("itg1");
    chk("itg1_u", u1, 60000000);
    wait_ch0("itg2");
    chk("itg2_u", u1, 100000000);
    wait_ch0("itg3");
    chk("itg3_u", u1, 100000000);
    wait_idle();
    ki = '0;
    kd = 16'sh0100;
    set_ch(0, 32'd0, 32'd0);
    pulse_clr();
    wait_ch0("der1");
    chk("der1_u", u1, 0);
    next_cycle();
    set_ch(0, 32'd500, 32'd0);
    wait_ch0("der2");
    chk("der2_u", u1, 500);
    wait_ch0("der3");
    chk("der3_u", u1, 0);
    wait_idle();
    kd = '0;
    kp = 16'sh7FFF;
    set_ch(0, 32'h7FFFFFFF, 32'h80000000);
    wait_ch0("sat");
    chk("sat_u", u1, OMAX);
    wait_idle();
    kp = 16'sh0100;
    set_ch(0, 32'd10, 32'd0);
    set_ch(1, 32'd20, 32'd0);
    wait_ch0("clr_ch0");
    chk("clr_ch0_u", u1, 10);
    repeat (3) next_cycle();
    clr = 1'b1;
    @(negedge clk);
    chk("clr_busy_before", busy1, 1);
    next_cycle();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_busy_after", busy1, 0);
    chk("clr_no_valid", uv1, 0);
    repeat (4) begin
      @(negedge clk);
      chk("clr_no_ch1", uv1, 0);
    end
    chk("clr_u_hold", u1, 10);
    repeat (20) @(negedge clk);
    chk("ovr_set", ovr2, 1);
    next_cycle();
    pulse_clr();
    @(negedge clk);
    chk("ovr_clr", ovr2, 0);
    chk("ovr_clr_busy", busy2, 0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = busy2;
    end
    if (!hit) miss("ovr_frame");
    chk("ovr_first_tick", ovr2, 0);
    repeat (7) @(negedge clk);
    chk("ovr_before_second", ovr2, 0);
    @(negedge clk);
    chk("ovr_after_second", ovr2, 1);
    wait_ch0("rst_mid");
    next_cycle();
    rstn = 1'b0;
    #1;
    chk("rst_mid_u", u1, 0);
    chk("rst_mid_ch", uch1, 0);
    chk("rst_mid_valid", uv1, 0);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_ovr", ovr2, 0);
    repeat (2) next_cycle();
    rstn = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      for (int c = 0; c < NCH; c++) if ($urandom % 4 == 0) set_ch(c, rnd32(), rnd32());
      en = ($urandom % 50) != 0;
      clr = ($urandom % 400) == 0;
      if (m_phase == 0 && $urandom % 8 == 0) begin
        kp = rgain();
        ki = rgain();
        kd = rgain();
      end
    end
    next_cycle();
    clr = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pid_sched.md
# pid_sched

Time-multiplexed PID scheduler that runs NCH independent PID loops on one shared signed multiplier. It fixes the sample rate, captures feedback and target for each channel, and keeps per-channel previous error and clamped integral. It sequences the P, I and D products through the multiplier, then saturates and publishes each control output with a valid strobe. It sits between the ADC/feedback capture logic and the actuator drivers, in place of one error/PID datapath per loop.

## Interface
- NCH, 2: number of PID channels (1–8).
- TICK_DIV, 1000: clk cycles per sample period (must be ≥ 6·NCH+2).
- ITG_MAX, 100000000: integral clamp magnitude (±ITG_MAX).
- OUT_MAX, 2147483647: output clamp magnitude (±OUT_MAX).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  enable sample ticks.
- clr  in  1  synchronous clear of all loop state.
- sig_in  in  32·NCH  packed signed feedback; channel c at [32c+31:32c].
- target  in  32·NCH  packed signed setpoints, same packing.
- kp, ki, kd  in  16 each  signed gains, Q8.8.
- u  out  32  signed control output.
- u_ch  out  max(1,clog2(NCH))  channel index of u.
- u_valid  out  1  one-cycle strobe, u/u_ch valid.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: tick arrived while busy.

## Operation
- Tick counter counts 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1) && en. Counter runs regardless of en.
- FSM states: IDLE, LOAD, MUL_P, MUL_I, MUL_D, SAT, OUT. Channel index ch.
- IDLE: on tick, ch←0 and go to LOAD.
- LOAD: select sig_in/target of ch.
  - e = sat32(target − sig_in), computed at 33 bits.
  - d = e − e1[ch], 33 bits.
  - sum_new = clamp(sum[ch] + e, ±ITG_MAX), computed at 34 bits.
  - acc←0.
- MUL_P: acc += e·kp. MUL_I: acc += sum_new·ki. MUL_D: acc += d·kd.
  - Single 34×16 signed multiplier; acc is 52 bits signed.
- SAT: y = acc >>> 8 (arithmetic); u_next = clamp(y, ±OUT_MAX).
- OUT: u←u_next, u_ch←ch, u_valid=1; e1[ch]←e, sum[ch]←sum_new.
  - If ch == NCH−1, go to IDLE; else ch+1 and go to LOAD.
- busy = (state != IDLE).
- Tick while busy: tick dropped, overrun←1. Only clr or reset clears overrun.
- en deasserted mid-frame: the frame completes; later ticks are suppressed.
- clr (highest priority, any state): abort the frame and return to IDLE. Zero all e1, sum and overrun. No u_valid in that cycle; u holds its last value. A tick in the same cycle as clr is ignored.
- ki = 0: integral still accumulates and clamps.

## Timing
- Reset values: u=0, u_ch=0, u_valid=0, busy=0, overrun=0, all e1/sum=0, count=0, state IDLE.
- First tick at cycle TICK_DIV−1 after rstn release; subsequent ticks every TICK_DIV cycles.
- Tick in cycle T → LOAD at T+1 → u_valid for ch0 at T+6; channel c at T+6+6c.
- busy drops the cycle after the last OUT. Frame length is 6·NCH cycles.
- Inputs are sampled only in LOAD of their channel; changes at other times have no effect.

## Structure
- Package pid_pkg holds:
  - the state enum;
  - Q-format constant FRAC=8;
  - ACC_W=52;
  - sat/clamp functions (sat32, clamp_sym).
- Sub-module pid_tick_gen (counter + en gating) is natural.
- Per-channel e1/sum go in register arrays indexed by ch, not RAM.

## Test plan
- NCH=2, TICK_DIV=16, kp=0x0100, ki=kd=0; ch0 target=1000, sig=400 → u_valid at cycle T+6 with u=600, u_ch=0; ch1 at T+12.
- ki=0x0100, kp=kd=0, constant e=60000000 → u=60000000, then 100000000 (clamped), then held at 100000000.
- kd=0x0100 only, e steps 0→500 between frames → u=500, then 0 on the next frame.
- target=0x7FFFFFFF, sig=0x80000000, kp=0x7FFF → e saturates to 0x7FFFFFFF; u=OUT_MAX.
- en held high, TICK_DIV=8, NCH=2 (frame 12 > 8) → overrun=1 after the second tick; clr pulse → overrun=0, busy=0, e1/sum=0.
- Assert clr in MUL_I of ch1 → no u_valid for ch1, busy low next cycle; rstn low mid-frame → all outputs at reset values immediately.
